comparator_response_checker: RTL and testbench

//   Hardware response checker that sits at the output end of the 2-bit comparator test path.
//   It accepts a stream of (x, y, z) samples on a valid/ready handshake.
//   For each sample it computes the expected z from x and y and counts mismatches.
//   It latches the first failing sample and reports done/pass after NUM_SAMPLES samples.

---
 rtl/comparator_check_pkg.sv | 15 +
 rtl/comparator_ref_model.sv | 25 ++
 rtl/comparator_response_checker.sv | 181 ++++++++++++++++++
 tb/tb_comparator_response_checker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_check_pkg.sv
// Shared definitions for the comparator response checker: FSM states and
// the compare-mode encodings understood by the reference model.
package comparator_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MODE_EQ = 0;
    localparam int MODE_GT = 1;
    localparam int MODE_LT = 2;

endpackage

// File: rtl/comparator_ref_model.sv
// Combinational golden model of the 2-bit comparator under test.
// Operands are treated as W-bit unsigned values.
module comparator_ref_model
    import comparator_check_pkg::*;
#(
    parameter int W        = 2,
    parameter int CMP_MODE = MODE_EQ
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         z_exp
);

    // Select the expected relation for the configured mode
    always_comb begin
        z_exp = 1'b0;
        case (CMP_MODE)
            MODE_EQ: z_exp = (x == y);
            MODE_GT: z_exp = (x > y);
            MODE_LT: z_exp = (x < y);
            default: z_exp = 1'b0;
        endcase
    end

endmodule

// File: rtl/comparator_response_checker.sv
// Checks a stream of (x, y, z) comparator responses against a reference model,
// counting mismatches and latching the first failing sample of each run.
module comparator_response_checker
    import comparator_check_pkg::*;
#(
    parameter int W           = 2,
    parameter int NUM_SAMPLES = 7,
    parameter int CW          = 8,
    parameter int CMP_MODE    = MODE_EQ
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  y,
    input  logic          z,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] sample_count,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] first_err_idx,
    output logic [W-1:0]  first_err_x,
    output logic [W-1:0]  first_err_y,
    output logic          first_err_z
);

    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_SAMPLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : (v + CNT_ONE);
    endfunction

    state_t        state_q, state_d;
    logic          s_ready_q, s_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [CW-1:0] sample_count_q, sample_count_d;
    logic [CW-1:0] err_count_q, err_count_d;
    logic [CW-1:0] first_err_idx_q, first_err_idx_d;
    logic [W-1:0]  first_err_x_q, first_err_x_d;
    logic [W-1:0]  first_err_y_q, first_err_y_d;
    logic          first_err_z_q, first_err_z_d;

    logic z_exp_s;
    logic accept_s;

    comparator_ref_model #(
        .W        (W),
        .CMP_MODE (CMP_MODE)
    ) u_ref (
        .x     (x),
        .y     (y),
        .z_exp (z_exp_s)
    );

    // s_ready_q is high exactly while in RUN, so it doubles as the accept qualifier
    assign accept_s = s_valid && s_ready_q;

    // Next-state, counter and first-error capture logic
    always_comb begin
        state_d         = state_q;
        s_ready_d       = s_ready_q;
        busy_d          = busy_q;
        done_d          = done_q;
        pass_d          = pass_q;
        sample_count_d  = sample_count_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        first_err_x_d   = first_err_x_q;
        first_err_y_d   = first_err_y_q;
        first_err_z_d   = first_err_z_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d         = ST_RUN;
                    s_ready_d       = 1'b1;
                    busy_d          = 1'b1;
                    done_d          = 1'b0;
                    pass_d          = 1'b0;
                    sample_count_d  = {CW{1'b0}};
                    err_count_d     = {CW{1'b0}};
                    first_err_idx_d = {CW{1'b0}};
                    first_err_x_d   = {W{1'b0}};
                    first_err_y_d   = {W{1'b0}};
                    first_err_z_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    sample_count_d = sample_count_q + CNT_ONE;
                    if (z != z_exp_s) begin
                        err_count_d = sat_inc(err_count_q);
                        if (err_count_q == {CW{1'b0}}) begin
                            first_err_idx_d = sample_count_q;
                            first_err_x_d   = x;
                            first_err_y_d   = y;
                            first_err_z_d   = z;
                        end else begin
                            first_err_idx_d = first_err_idx_q;
                        end
                    end else begin
                        err_count_d = err_count_q;
                    end
                    if (sample_count_q == LAST_IDX) begin
                        state_d   = ST_DONE;
                        s_ready_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        pass_d    = (err_count_d == {CW{1'b0}});
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d         = ST_IDLE;
                s_ready_d       = 1'b0;
                busy_d          = 1'b0;
                done_d          = 1'b0;
                pass_d          = 1'b0;
                sample_count_d  = {CW{1'b0}};
                err_count_d     = {CW{1'b0}};
                first_err_idx_d = {CW{1'b0}};
                first_err_x_d   = {W{1'b0}};
                first_err_y_d   = {W{1'b0}};
                first_err_z_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset discards any partial run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            s_ready_q       <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            sample_count_q  <= {CW{1'b0}};
            err_count_q     <= {CW{1'b0}};
            first_err_idx_q <= {CW{1'b0}};
            first_err_x_q   <= {W{1'b0}};
            first_err_y_q   <= {W{1'b0}};
            first_err_z_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            s_ready_q       <= s_ready_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            sample_count_q  <= sample_count_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_x_q   <= first_err_x_d;
            first_err_y_q   <= first_err_y_d;
            first_err_z_q   <= first_err_z_d;
        end
    end

    assign s_ready       = s_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign sample_count  = sample_count_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign first_err_x   = first_err_x_q;
    assign first_err_y   = first_err_y_q;
    assign first_err_z   = first_err_z_q;

endmodule

// File: tb/tb_comparator_response_checker.sv
// Directed, table-driven bench for comparator_response_checker (EQ default
// instance plus a CW=2 / NUM_SAMPLES=3 / GT instance for saturation).
module tb_comparator_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, s_valid, start2, s_valid2;
    logic [1:0] x, y;
    logic       z;

    logic       s_ready, busy, done, pass;
    logic [7:0] sample_count, err_count, first_err_idx;
    logic [1:0] first_err_x, first_err_y;
    logic       first_err_z;

    logic       s_ready2, busy2, done2, pass2;
    logic [1:0] sample_count2, err_count2, first_err_idx2;
    logic [1:0] first_err_x2, first_err_y2;
    logic       first_err_z2;

    comparator_response_checker dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .x(x), .y(y), .z(z), .busy(busy), .done(done), .pass(pass),
        .sample_count(sample_count), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_x(first_err_x),
        .first_err_y(first_err_y), .first_err_z(first_err_z)
    );

    comparator_response_checker #(.W(2), .NUM_SAMPLES(3), .CW(2), .CMP_MODE(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .s_valid(s_valid2), .s_ready(s_ready2),
        .x(x), .y(y), .z(z), .busy(busy2), .done(done2), .pass(pass2),
        .sample_count(sample_count2), .err_count(err_count2),
        .first_err_idx(first_err_idx2), .first_err_x(first_err_x2),
        .first_err_y(first_err_y2), .first_err_z(first_err_z2)
    );

    typedef struct {
        logic [1:0] x;
        logic [1:0] y;
        logic       z;
        logic [7:0] cnt;
        logic [7:0] err;
    } vec_t;

    vec_t tbl[14];
    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] sx, input logic [1:0] sy, input logic sz);
        s_valid = 1'b1;
        x = sx;
        y = sy;
        z = sz;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send2(input logic [1:0] sx, input logic [1:0] sy, input logic sz);
        s_valid2 = 1'b1;
        x = sx;
        y = sy;
        z = sz;
        tick();
        s_valid2 = 1'b0;
    endtask

    initial begin
        // run 0: all correct in EQ mode; run 1: sample 3 answered wrongly
        tbl[0]  = '{2'd0, 2'd0, 1'b1, 8'd1, 8'd0};
        tbl[1]  = '{2'd1, 2'd0, 1'b0, 8'd2, 8'd0};
        tbl[2]  = '{2'd1, 2'd1, 1'b1, 8'd3, 8'd0};
        tbl[3]  = '{2'd1, 2'd3, 1'b0, 8'd4, 8'd0};
        tbl[4]  = '{2'd3, 2'd3, 1'b1, 8'd5, 8'd0};
        tbl[5]  = '{2'd3, 2'd1, 1'b0, 8'd6, 8'd0};
        tbl[6]  = '{2'd3, 2'd0, 1'b0, 8'd7, 8'd0};
        tbl[7]  = '{2'd0, 2'd0, 1'b1, 8'd1, 8'd0};
        tbl[8]  = '{2'd1, 2'd0, 1'b0, 8'd2, 8'd0};
        tbl[9]  = '{2'd1, 2'd1, 1'b1, 8'd3, 8'd0};
        tbl[10] = '{2'd1, 2'd3, 1'b1, 8'd4, 8'd1};
        tbl[11] = '{2'd3, 2'd3, 1'b1, 8'd5, 8'd1};
        tbl[12] = '{2'd3, 2'd1, 1'b0, 8'd6, 8'd1};
        tbl[13] = '{2'd3, 2'd0, 1'b0, 8'd7, 8'd1};

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; start2 = 1'b0; s_valid2 = 1'b0;
        x = 2'd0; y = 2'd0; z = 1'b0;
        repeat (2) tick();
        chk("rst_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_cnt", sample_count, 0);
        chk("rst_err", err_count, 0);
        rst = 1'b0;
        tick();

        // samples offered in IDLE must not be accepted
        s_valid = 1'b1; x = 2'd1; y = 2'd2; z = 1'b1;
        repeat (3) tick();
        s_valid = 1'b0;
        chk("idle_cnt", sample_count, 0);
        chk("idle_err", err_count, 0);
        chk("idle_ready", s_ready, 0);

        for (int i = 0; i < 14; i++) begin
            if (i % 7 == 0) begin
                pulse_start();
                chk("run_clr_cnt", sample_count, 0);
                chk("run_clr_err", err_count, 0);
                chk("run_busy", busy, 1);
                chk("run_ready", s_ready, 1);
                chk("run_done_low", done, 0);
            end
            send(tbl[i].x, tbl[i].y, tbl[i].z);
            chk($sformatf("cnt_%0d", i), sample_count, tbl[i].cnt);
            chk($sformatf("err_%0d", i), err_count, tbl[i].err);
            if (i % 7 == 6) begin
                chk("end_done", done, 1);
                chk("end_busy", busy, 0);
                chk("end_ready", s_ready, 0);
                chk("end_pass", pass, (i == 6) ? 1 : 0);
            end else begin
                chk("mid_done", done, 0);
            end
        end
        chk("fe_idx", first_err_idx, 3);
        chk("fe_x", first_err_x, 1);
        chk("fe_y", first_err_y, 3);
        chk("fe_z", first_err_z, 1);

        // DONE holds results and ignores samples
        s_valid = 1'b1; x = 2'd0; y = 2'd1; z = 1'b1;
        repeat (3) tick();
        s_valid = 1'b0;
        chk("hold_cnt", sample_count, 7);
        chk("hold_err", err_count, 1);
        chk("hold_done", done, 1);
        chk("hold_fe_idx", first_err_idx, 3);

        // restart from DONE clears first-error fields; start in RUN is ignored
        pulse_start();
        chk("rst2_fe_idx", first_err_idx, 0);
        chk("rst2_fe_x", first_err_x, 0);
        chk("rst2_err", err_count, 0);
        send(2'd0, 2'd0, 1'b1);
        send(2'd1, 2'd1, 1'b1);
        start = 1'b1;
        send(2'd2, 2'd2, 1'b1);
        start = 1'b0;
        chk("start_in_run_cnt", sample_count, 3);
        chk("start_in_run_busy", busy, 1);
        send(2'd2, 2'd0, 1'b0);
        send(2'd3, 2'd2, 1'b0);
        send(2'd0, 2'd1, 1'b0);
        send(2'd2, 2'd3, 1'b0);
        chk("b2b_done", done, 1);
        chk("b2b_pass", pass, 1);
        chk("b2b_cnt", sample_count, 7);

        // asynchronous reset mid-run discards the partial run
        pulse_start();
        send(2'd0, 2'd0, 1'b1);
        send(2'd1, 2'd1, 1'b1);
        send(2'd2, 2'd2, 1'b1);
        send(2'd3, 2'd3, 1'b0);
        chk("part_cnt", sample_count, 4);
        chk("part_err", err_count, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_cnt", sample_count, 0);
        chk("arst_err", err_count, 0);
        chk("arst_fe_x", first_err_x, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", s_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);
        pulse_start();
        for (int k = 0; k < 7; k++) begin
            send(2'(k % 4), 2'(k % 4), 1'b1);
        end
        chk("clean_done", done, 1);
        chk("clean_pass", pass, 1);
        chk("clean_cnt", sample_count, 7);

        // small-counter GT instance: every answer wrong, err saturates at 3
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("d2_busy", busy2, 1);
        send2(2'd2, 2'd1, 1'b0);
        send2(2'd0, 2'd3, 1'b1);
        chk("d2_err_mid", err_count2, 2);
        send2(2'd3, 2'd3, 1'b1);
        chk("d2_err_sat", err_count2, 3);
        chk("d2_cnt", sample_count2, 3);
        chk("d2_done", done2, 1);
        chk("d2_pass", pass2, 0);
        chk("d2_fe_idx", first_err_idx2, 0);
        chk("d2_fe_x", first_err_x2, 2);
        chk("d2_fe_y", first_err_y2, 1);
        chk("d2_fe_z", first_err_z2, 0);
        tick();
        chk("d2_hold_err", err_count2, 3);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("d2_re_cnt", sample_count2, 0);
        chk("d2_re_err", err_count2, 0);
        chk("d2_re_fe_x", first_err_x2, 0);
        chk("d2_re_busy", busy2, 1);
        chk("d2_re_done", done2, 0);
        send2(2'd2, 2'd1, 1'b1);
        send2(2'd0, 2'd3, 1'b0);
        send2(2'd3, 2'd3, 1'b0);
        chk("d2_ok_done", done2, 1);
        chk("d2_ok_pass", pass2, 1);
        chk("d2_ok_err", err_count2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
